// File: rtl/mult_job_sequencer_tt_if.sv
// mult_job_sequencer_tt_if: operand, multiplier and result channels of the job sequencer, each with a taint shadow.
interface mult_job_sequencer_tt_if #(
    parameter int WIDTH = 1024,
    parameter int CW = 12
);
    logic in_valid, in_valid_t, in_ready, in_ready_t;
    logic [WIDTH-1:0] in_multiplier, in_multiplier_t, in_multiplicand, in_multiplicand_t;
    logic start, start_t;
    logic [WIDTH-1:0] multiplier, multiplier_t, multiplicand, multiplicand_t;
    logic [2*WIDTH-1:0] product, product_t;
    logic productDone, productDone_t;
    logic out_valid, out_valid_t, out_ready, out_ready_t;
    logic [2*WIDTH-1:0] out_product, out_product_t;
    logic [CW-1:0] busy_cycles;
    logic timeout;
    modport master (
        input in_valid, in_valid_t, in_multiplier, in_multiplier_t, in_multiplicand, in_multiplicand_t,
        input product, product_t, productDone, productDone_t, out_ready, out_ready_t,
        output in_ready, in_ready_t, start, start_t, multiplier, multiplier_t, multiplicand, multiplicand_t,
        output out_valid, out_valid_t, out_product, out_product_t, busy_cycles, timeout
    );
    modport slave (
        output in_valid, in_valid_t, in_multiplier, in_multiplier_t, in_multiplicand, in_multiplicand_t,
        output product, product_t, productDone, productDone_t, out_ready, out_ready_t,
        input in_ready, in_ready_t, start, start_t, multiplier, multiplier_t, multiplicand, multiplicand_t,
        input out_valid, out_valid_t, out_product, out_product_t, busy_cycles, timeout
    );
endinterface

// File: rtl/mult_job_sequencer_tt.sv
// mult_job_sequencer_tt: feeds operand pairs to a sequential multiplier and buffers its product, with GLIFT taint shadows.
// Define MULT_SEQ_TIMEOUT_EN to abort jobs whose productDone never arrives.
module mult_job_sequencer_tt #(
    parameter int WIDTH = 1024,
    parameter int CW = 12
) (
    input logic clk,
    input logic rst,
    mult_job_sequencer_tt_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, BUSY = 2'd2, HOLD = 2'd3;
    logic [1:0] state;
    logic state_t;
    logic [WIDTH-1:0] mult, mult_t, mcand, mcand_t;
    logic [2*WIDTH-1:0] prod, prod_t;
    logic [CW-1:0] busy;
    logic armed, accept_t;
    // busy is cleared on accept, so zero marks the first BUSY cycle where a stale productDone is ignored
    assign armed = busy != '0;
    assign accept_t = state_t | bus.in_valid_t;
`ifdef MULT_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] TO = CW'(2 * WIDTH + 8);
    logic timeout_r;
    assign bus.timeout = timeout_r;
`else
    assign bus.timeout = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            state_t <= 1'b0;
            mult <= '0;
            mult_t <= '0;
            mcand <= '0;
            mcand_t <= '0;
            prod <= '0;
            prod_t <= '0;
            busy <= '0;
`ifdef MULT_SEQ_TIMEOUT_EN
            timeout_r <= 1'b0;
`endif
        end else begin
`ifdef MULT_SEQ_TIMEOUT_EN
            timeout_r <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    state_t <= accept_t;
                    if (bus.in_valid) begin
                        state <= START;
                        mult <= bus.in_multiplier;
                        mult_t <= bus.in_multiplier_t | {WIDTH{accept_t}};
                        mcand <= bus.in_multiplicand;
                        mcand_t <= bus.in_multiplicand_t | {WIDTH{accept_t}};
                        busy <= '0;
                    end
                end
                START: state <= BUSY;
                BUSY: begin
                    busy <= &busy ? busy : busy + CW'(1);
                    if (armed && bus.productDone_t) state_t <= 1'b1;
                    if (armed && bus.productDone) begin
                        state <= HOLD;
                        prod <= bus.product;
                        prod_t <= bus.product_t | {2*WIDTH{state_t | bus.productDone_t}};
                    end
`ifdef MULT_SEQ_TIMEOUT_EN
                    else if (busy >= TO) begin
                        state <= IDLE;
                        timeout_r <= 1'b1;
                    end
`endif
                end
                default: begin
                    // a clean handshake is the only way (besides reset) to drop control taint
                    if (bus.out_ready_t) state_t <= 1'b1;
                    else if (bus.out_ready) state_t <= 1'b0;
                    if (bus.out_ready) state <= IDLE;
                end
            endcase
        end
    end
    assign bus.in_ready = state == IDLE;
    assign bus.in_ready_t = state_t;
    assign bus.start = state == START;
    assign bus.start_t = state_t;
    assign bus.out_valid = state == HOLD;
    assign bus.out_valid_t = state_t;
    assign bus.multiplier = mult;
    assign bus.multiplier_t = mult_t;
    assign bus.multiplicand = mcand;
    assign bus.multiplicand_t = mcand_t;
    assign bus.out_product = prod;
    assign bus.out_product_t = prod_t;
    assign bus.busy_cycles = busy;
endmodule

// File: tb/tb_mult_job_sequencer_tt.sv
// tb_mult_job_sequencer_tt: directed scoreboard bench for mult_job_sequencer_tt (WIDTH=8, CW=6) with a delay-programmable model multiplier.
module tb_mult_job_sequencer_tt;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    int starts = 0;
    int dly = 0;
    int cnt = 0;
    logic force_done = 1'b0;
    logic pd_t = 1'b0;
    logic [7:0] ma = '0, mb = '0, mat = '0, mbt = '0;
    typedef struct {
        logic [15:0] p;
        logic [15:0] pt;
        logic vt;
        logic [5:0] bc;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    mult_job_sequencer_tt_if #(.WIDTH(8), .CW(6)) bus ();
    mult_job_sequencer_tt #(.WIDTH(8), .CW(6)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // model multiplier: productDone rises in the dly-th BUSY cycle after the start pulse
    always @(posedge clk) begin
        if (bus.start) begin
            starts <= starts + 1;
            ma <= bus.multiplier;
            mb <= bus.multiplicand;
            mat <= bus.multiplier_t;
            mbt <= bus.multiplicand_t;
            cnt <= dly;
        end else if (cnt != 0) cnt <= cnt - 1;
    end
    assign bus.productDone = force_done | (cnt == 1);
    assign bus.productDone_t = pd_t;
    assign bus.product = 16'(ma) * 16'(mb);
    assign bus.product_t = {mbt, mat};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic accept_job(input string tag, input logic [7:0] a, b, at, bt, input logic vt,
                              input int d, input logic [5:0] bc);
        @(negedge clk);
        dly = d;
        bus.in_valid = 1'b1;
        bus.in_valid_t = vt;
        bus.in_multiplier = a;
        bus.in_multiplicand = b;
        bus.in_multiplier_t = at;
        bus.in_multiplicand_t = bt;
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_valid_t = 1'b0;
        sb.push_back('{p: 16'(a) * 16'(b), pt: vt ? 16'hffff : {bt, at}, vt: vt, bc: bc});
        chk({tag, "_start"}, bus.start, 1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_out_valid"}, bus.out_valid, 1);
    endtask

    task automatic check_front(input string tag);
        chk({tag, "_sb_size"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_product"}, bus.out_product, e.p);
            chk({tag, "_product_t"}, bus.out_product_t, e.pt);
            chk({tag, "_out_valid_t"}, bus.out_valid_t, e.vt);
            chk({tag, "_busy_cycles"}, bus.busy_cycles, e.bc);
        end
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_rel_out_valid"}, bus.out_valid, 0);
        chk({tag, "_rel_in_ready"}, bus.in_ready, 1);
        chk({tag, "_rel_in_ready_t"}, bus.in_ready_t, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_valid_t = 1'b0;
        bus.in_multiplier = '0;
        bus.in_multiplier_t = '0;
        bus.in_multiplicand = '0;
        bus.in_multiplicand_t = '0;
        bus.out_ready = 1'b0;
        bus.out_ready_t = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_start", bus.start, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_timeout", bus.timeout, 0);
        chk("rst_busy", bus.busy_cycles, 0);
        chk("rst_taints", {bus.in_ready_t, bus.start_t, bus.out_valid_t, bus.multiplier_t,
                           bus.multiplicand_t, bus.out_product_t}, 0);
        chk("rst_regs", {bus.multiplier, bus.multiplicand, bus.out_product}, 0);

        // untainted 13 x 11, done in 9th BUSY cycle
        accept_job("j1", 8'd13, 8'd11, 8'h00, 8'h00, 1'b0, 9, 6'd9);
        wait_valid("j1");
        check_front("j1");
        chk("j1_starts", starts, 1);
        release_out("j1");

        // operand taint only
        accept_job("j2", 8'd200, 8'd250, 8'h01, 8'h00, 1'b0, 5, 6'd5);
        chk("j2_mult_t", bus.multiplier_t, 8'h01);
        chk("j2_mcand_t", bus.multiplicand_t, 8'h00);
        chk("j2_start_t", bus.start_t, 0);
        wait_valid("j2");
        check_front("j2");
        release_out("j2");

        // control taint on in_valid
        accept_job("j3", 8'd6, 8'd7, 8'h00, 8'h00, 1'b1, 3, 6'd3);
        chk("j3_start_t", bus.start_t, 1);
        wait_valid("j3");
        check_front("j3");
        release_out("j3");

        // back-pressure with a new pair already offered during HOLD
        accept_job("j4", 8'd255, 8'd255, 8'h00, 8'h00, 1'b0, 4, 6'd4);
        wait_valid("j4");
        bus.in_valid = 1'b1;
        bus.in_multiplier = 8'd5;
        bus.in_multiplicand = 8'd6;
        bus.in_multiplier_t = 8'h00;
        bus.in_multiplicand_t = 8'h00;
        dly = 3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_product", bus.out_product, 16'd65025);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        check_front("j4");
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_idle_in_ready", bus.in_ready, 1);
        chk("bp_no_same_cycle_start", bus.start, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        sb.push_back('{p: 16'd30, pt: 16'h0000, vt: 1'b0, bc: 6'd3});
        chk("bp_next_start", bus.start, 1);
        wait_valid("j5");
        check_front("j5");
        release_out("j5");

        // stale done held from START onward: capture only at end of BUSY cycle 2
        force_done = 1'b1;
        accept_job("sd", 8'd3, 8'd4, 8'h00, 8'h00, 1'b0, 0, 6'd2);
        @(negedge clk);
        chk("sd_busy1_no_capture", bus.out_valid, 0);
        @(negedge clk);
        chk("sd_busy2_no_capture", bus.out_valid, 0);
        @(negedge clk);
        chk("sd_capture", bus.out_valid, 1);
        force_done = 1'b0;
        check_front("sd");
        release_out("sd");

        // reset while BUSY; the model's late productDone must be ignored
        accept_job("rb", 8'd9, 8'd9, 8'h00, 8'h00, 1'b0, 30, 6'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("rb_in_ready", bus.in_ready, 1);
        chk("rb_start", bus.start, 0);
        chk("rb_out_valid", bus.out_valid, 0);
        chk("rb_busy", bus.busy_cycles, 0);
        chk("rb_regs", {bus.multiplier, bus.multiplicand, bus.out_product}, 0);
        repeat (35) @(negedge clk);
        chk("rb_late_done_out_valid", bus.out_valid, 0);
        chk("rb_late_done_in_ready", bus.in_ready, 1);

`ifdef MULT_SEQ_TIMEOUT_EN
        accept_job("to", 8'd1, 8'd1, 8'h00, 8'h00, 1'b0, 0, 6'd0);
        sb.delete();
        for (int n = 0; n < 100 && !bus.timeout; n++) @(negedge clk);
        chk("to_pulse", bus.timeout, 1);
        chk("to_out_valid", bus.out_valid, 0);
        chk("to_in_ready", bus.in_ready, 1);
        @(negedge clk);
        chk("to_one_cycle", bus.timeout, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
